// File: rtl/rr_arb_1hot_sel.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_1hot_sel
// Description : Round-robin arbiter producing a registered one-hot select for
//               a downstream one-hot mux with default. A grant is held until
//               the consumer acks it, then priority rotates past the winner.
//               gnt is all-zero when idle so the mux falls back to default.
//               Optional macro RR_ARB_1HOT_SEL_LOCK_EN adds a lock input that
//               keeps the grant on the same requester across acked beats.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_1hot_sel #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            ack,
`ifdef RR_ARB_1HOT_SEL_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx
);

    localparam logic [0:0]      S_IDLE  = 1'b0;
    localparam logic [0:0]      S_GRANT = 1'b1;
    localparam logic [IDXW:0]   c_N     = (IDXW+1)'(N);
    localparam logic [IDXW-1:0] c_LAST  = IDXW'(N-1);

    logic [0:0]      r_state;
    logic [IDXW-1:0] r_ptr;
    logic [N-1:0]    r_gnt;
    logic            r_valid;
    logic [IDXW-1:0] r_idx;

    logic            w_lock;
    logic            w_own_req;
    logic [IDXW-1:0] w_nxt_ptr;
    logic [IDXW-1:0] w_base;
    logic [2*N-1:0]  w_dbl;
    logic            w_hit;
    logic [IDXW-1:0] w_off;
    logic [IDXW:0]   w_sum;
    logic [IDXW-1:0] w_sel_idx;
    logic [N-1:0]    w_sel_1hot;

`ifdef RR_ARB_1HOT_SEL_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // Owner still requesting; a drop releases the grant (even when locked)
    assign w_own_req = req[r_idx];

    // Rotated pointer after the current winner retires, wrapping at N-1
    assign w_nxt_ptr = (r_idx == c_LAST) ? '0 : r_idx + 1'b1;

    // When acking, the next search already starts from the rotated pointer
    assign w_base = (r_state == S_GRANT) ? w_nxt_ptr : r_ptr;

    // Circular first-set search from w_base: rotate a doubled copy of req
    // so the wrap-around scan becomes a plain lowest-bit priority encode
    always_comb begin
        w_dbl = {req, req} >> w_base;
        w_hit = 1'b0;
        w_off = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_hit = 1'b1;
                w_off = IDXW'(k);
            end
        end
        w_sum = {1'b0, w_base} + {1'b0, w_off};
        if (w_sum >= c_N) begin
            w_sum = w_sum - c_N;
        end
        w_sel_idx  = w_sum[IDXW-1:0];
        w_sel_1hot = {{(N-1){1'b0}}, 1'b1} << w_sel_idx;
    end

    // Grant FSM: issue, hold until ack/withdraw, rotate pointer on ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_state <= S_GRANT;
                        r_gnt   <= w_sel_1hot;
                        r_valid <= 1'b1;
                        r_idx   <= w_sel_idx;
                    end
                end
                S_GRANT: begin
                    if (ack && w_lock && w_own_req) begin
                        // Locked burst beat retired: keep owner, keep pointer
                        r_state <= S_GRANT;
                    end else if (ack) begin
                        r_ptr <= w_nxt_ptr;
                        if (w_hit) begin
                            r_gnt <= w_sel_1hot;
                            r_idx <= w_sel_idx;
                        end else begin
                            r_state <= S_IDLE;
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                            r_idx   <= '0;
                        end
                    end else if (!w_own_req) begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_valid;
    assign gnt_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_1hot_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_1hot_sel
// Description : Self-checking bench for rr_arb_1hot_sel (N=8). Directed
//               vector table plus hand sequences for fairness and, when
//               RR_ARB_1HOT_SEL_LOCK_EN is defined, locked bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_1hot_sel;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       ack;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
`ifdef RR_ARB_1HOT_SEL_LOCK_EN
    logic       lock;
`endif

    int total = 0;
    int bad   = 0;

    rr_arb_1hot_sel #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
`ifdef RR_ARB_1HOT_SEL_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [7:0] req;
        bit         ack;
        logic [7:0] eg;
        int         ei;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [7:0] rq, input bit a,
                       input logic [7:0] eg, input int ei);
        vec_t v;
        v.rst = r; v.req = rq; v.ack = a; v.eg = eg; v.ei = ei;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Drive inputs at negedge, let one posedge happen, sample 1 time unit later
    task automatic step(input bit r, input logic [7:0] rq, input bit a);
        @(negedge clk);
        rst_n = ~r;
        req   = rq;
        ack   = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] eg, input int ei);
        check({name, ".gnt"}, 32'(gnt), 32'(eg));
        check({name, ".valid"}, 32'(gnt_valid), 32'(|eg));
        check({name, ".idx"}, 32'(gnt_idx), 32'(ei));
    endtask

    // Per-cycle invariants; req captured at the edge that computed the grant
    logic [7:0] req_q;
    bit         mon_en = 1'b0;
    always @(posedge clk) req_q <= req;
    always @(negedge clk) begin
        if (mon_en) begin
            check("inv.onehot", 32'(gnt & (gnt - 8'd1)), 32'd0);
            check("inv.valid", 32'(gnt_valid), 32'(|gnt));
            check("inv.idx", 32'(gnt_idx), 32'(enc(gnt)));
            check("inv.noreq", 32'(gnt & ~req_q), 32'd0);
        end
    end

    int cnt[8];

    initial begin
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
`ifdef RR_ARB_1HOT_SEL_LOCK_EN
        lock  = 1'b0;
`endif
        // rst, req, ack, expected gnt, expected idx
        add(1, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 8'h00, 0);
        add(0, 8'h24, 0, 8'h04, 2);   // ptr 0 -> idx 2
        add(0, 8'h24, 1, 8'h20, 5);   // ptr 3 -> idx 5, no bubble
        add(0, 8'h24, 1, 8'h04, 2);   // ptr 6 wraps to idx 2
        add(0, 8'h00, 1, 8'h00, 0);   // ptr 3, nothing left -> idle
        add(0, 8'h00, 1, 8'h00, 0);   // ack while idle ignored
        add(0, 8'h80, 0, 8'h80, 7);
        add(0, 8'h81, 1, 8'h01, 0);   // idx 7 acked -> ptr 0
        add(0, 8'h00, 1, 8'h00, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        add(0, 8'h08, 0, 8'h08, 3);
        add(0, 8'h48, 0, 8'h08, 3);   // hold while other bits toggle
        add(0, 8'h08, 0, 8'h08, 3);
        add(0, 8'h48, 0, 8'h08, 3);
        add(0, 8'h08, 0, 8'h08, 3);
        add(0, 8'h40, 0, 8'h00, 0);   // owner withdraws -> idle, ptr stays 0
        add(0, 8'h48, 0, 8'h08, 3);   // ptr 0 still favours idx 3
        add(0, 8'h40, 1, 8'h40, 6);   // ack with withdraw counts as ack
        add(0, 8'h40, 1, 8'h40, 6);   // ptr 7: self wins at lowest priority
        add(1, 8'h40, 0, 8'h00, 0);   // reset mid-grant drops it
        add(0, 8'h40, 0, 8'h40, 6);
        add(0, 8'h00, 0, 8'h00, 0);

        step(1, 8'h00, 0);
        step(1, 8'h00, 0);
        mon_en = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].ack);
            expect_out($sformatf("vec%0d", i), tbl[i].eg, tbl[i].ei);
        end

        // Fairness: all request, ack every cycle, 16 grants 0..7,0..7
        foreach (cnt[i]) cnt[i] = 0;
        step(1, 8'hFF, 0);
        step(0, 8'hFF, 0);
        expect_out("fair0", 8'h01, 0);
        cnt[gnt_idx]++;
        for (int i = 1; i < 16; i++) begin
            step(0, 8'hFF, 1);
            expect_out($sformatf("fair%0d", i), 8'(1 << (i % 8)), i % 8);
            cnt[gnt_idx]++;
        end
        for (int i = 0; i < 8; i++) check($sformatf("fair.cnt%0d", i), 32'(cnt[i]), 32'd2);
        step(0, 8'h00, 1);
        expect_out("fair.end", 8'h00, 0);

`ifdef RR_ARB_1HOT_SEL_LOCK_EN
        step(1, 8'h00, 0);
        step(0, 8'h03, 0);
        expect_out("lock.g0", 8'h01, 0);
        lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h03, 1);
            expect_out($sformatf("lock.beat%0d", i), 8'h01, 0);
        end
        lock = 1'b0;
        step(0, 8'h03, 1);
        expect_out("lock.rel", 8'h02, 1);
        lock = 1'b1;
        step(0, 8'h01, 0);             // withdraw under lock releases
        expect_out("lock.wd", 8'h00, 0);
        lock = 1'b0;
`endif

        step(0, 8'h00, 0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
